// File: rtl/reg_writeback.sv
// Architectural register file and writeback stage: sixteen 64-bit registers,
// a per-register pending-write scoreboard, and two-cycle serialization of dual-destination results.
module reg_writeback (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  reserveValidIn,
   input  logic [3:0]            reserveRegIn,
   input  logic                  reserveSpecialValidIn,
   input  logic [3:0]            reserveSpecialRegIn,
   input  logic [3:0]            sourceReg1In,
   input  logic [3:0]            sourceReg2In,
   input  logic                  sourceReg1ValidIn,
   input  logic                  sourceReg2ValidIn,
   input  logic                  wbValidIn,
   output logic                  wbReadyOut,
   input  logic [3:0]            wbDestRegIn,
   input  logic [63:0]           wbResultIn,
   input  logic                  wbSpecialValidIn,
   input  logic [3:0]            wbSpecialRegIn,
   input  logic [63:0]           wbSpecialResultIn,
   output logic [15:0][63:0]     registerFileOut,
   output logic [15:0]           busyOut,
   output logic                  stallOut,
   output logic [31:0]           retireCountOut
);

   typedef enum logic {IDLE, SPECIAL} wbState_t;

   wbState_t          state;
   wbState_t          nextState;
   logic [15:0][63:0] regFile;
   logic [1:0]        pendCount [16];
   logic [1:0]        nextCount [16];
   logic [3:0]        specialReg;
   logic [63:0]       specialVal;
   logic [31:0]       retireCount;

   logic              releaseValid;
   logic [3:0]        releaseReg;
   logic [63:0]       releaseData;
   logic              acceptPrimary;
   logic              reserveAccept;
   logic              sourceHazard;
   logic              reserveOverflow;
   logic              reserveShared;
   logic [2:0]        primaryTotal;
   logic [2:0]        specialTotal;

   // State register; reset during SPECIAL drops the pending second write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: only a two-destination result leaves IDLE.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (wbValidIn && wbSpecialValidIn) nextState = SPECIAL;
         SPECIAL: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Output logic: ready is a pure function of state.
   always_comb begin
      wbReadyOut = 1'b0;
      case (state)
         IDLE:    wbReadyOut = 1'b1;
         SPECIAL: wbReadyOut = 1'b0;
         default: wbReadyOut = 1'b0;
      endcase
   end

   // One register write per cycle: the primary result in IDLE, the latched special value in SPECIAL.
   always_comb begin
      acceptPrimary = (state == IDLE) && wbValidIn;
      if (state == IDLE) begin
         releaseValid = wbValidIn;
         releaseReg   = wbDestRegIn;
         releaseData  = wbResultIn;
      end else begin
         releaseValid = 1'b1;
         releaseReg   = specialReg;
         releaseData  = specialVal;
      end
   end

   // Hazard stall from current counts; overflow considers both reserves of this instruction.
   always_comb begin
      sourceHazard = (sourceReg1ValidIn && (pendCount[sourceReg1In] != 2'd0)) ||
                     (sourceReg2ValidIn && (pendCount[sourceReg2In] != 2'd0));
      reserveShared = reserveSpecialValidIn && (reserveSpecialRegIn == reserveRegIn);
      primaryTotal  = {1'b0, pendCount[reserveRegIn]} + 3'd1 + {2'b00, reserveShared};
      specialTotal  = {1'b0, pendCount[reserveSpecialRegIn]} + 3'd1 + {2'b00, reserveShared};
      reserveOverflow = reserveValidIn &&
                        ((primaryTotal > 3'd3) || (reserveSpecialValidIn && (specialTotal > 3'd3)));
      stallOut      = sourceHazard || reserveOverflow;
      reserveAccept = reserveValidIn && !stallOut;
   end

   // Per-register count update; a release at zero is a protocol error and leaves the count at zero.
   always_comb begin
      for (int r = 0; r < 16; r++) begin
         logic [2:0] sum;
         logic [2:0] inc;
         inc = {2'b00, reserveAccept && (reserveRegIn == 4'(r))} +
               {2'b00, reserveAccept && reserveSpecialValidIn && (reserveSpecialRegIn == 4'(r))};
         sum = {1'b0, pendCount[r]} + inc;
         if (releaseValid && (releaseReg == 4'(r)) && (sum != 3'd0)) begin
            sum = sum - 3'd1;
         end
         if (sum > 3'd3) begin
            sum = 3'd3;
         end
         nextCount[r] = sum[1:0];
      end
   end

   // Scoreboard counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 16; r++) begin
            pendCount[r] <= 2'd0;
         end
      end else begin
         for (int r = 0; r < 16; r++) begin
            pendCount[r] <= nextCount[r];
         end
      end
   end

   // Register file, special-destination latch and retire counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regFile     <= '0;
         specialReg  <= 4'd0;
         specialVal  <= 64'd0;
         retireCount <= 32'd0;
      end else begin
         if (releaseValid) begin
            regFile[releaseReg] <= releaseData;
         end
         if (acceptPrimary) begin
            retireCount <= retireCount + 32'd1;
            if (wbSpecialValidIn) begin
               specialReg <= wbSpecialRegIn;
               specialVal <= wbSpecialResultIn;
            end
         end
      end
   end

   always_comb begin
      for (int r = 0; r < 16; r++) begin
         busyOut[r] = (pendCount[r] != 2'd0);
      end
   end

   assign registerFileOut = regFile;
   assign retireCountOut  = retireCount;

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Register-file owner and writeback stage for the x86-64 pipeline: holds the sixteen 64-bit architectural registers and accepts results from execute over a valid/ready handshake. Two-destination results (IMUL RDX:RAX) are serialized over two cycles. Keeps a per-register pending-write scoreboard, reserved by the read stage at issue and released at writeback. Drives `registerFileOut` and the hazard stall back into the read stage.

## Interface
- No parameters; 16 registers × 64 bits, 4-bit register indices, fixed.
- `clk`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `reserveValidIn`  in  1  read stage issues an instruction this cycle.
- `reserveRegIn`  in  4  primary destination to mark pending.
- `reserveSpecialValidIn`  in  1  instruction also writes a second destination.
- `reserveSpecialRegIn`  in  4  second destination (RDX for IMUL).
- `sourceReg1In`/`sourceReg2In`  in  4  read-stage source indices.
- `sourceReg1ValidIn`/`sourceReg2ValidIn`  in  1  source index in use.
- `wbValidIn`  in  1  execute presents a result.
- `wbReadyOut`  out  1  block accepts the result this cycle.
- `wbDestRegIn`  in  4  primary destination.
- `wbResultIn`  in  64  primary value.
- `wbSpecialValidIn`  in  1  second destination present.
- `wbSpecialRegIn`  in  4  second destination.
- `wbSpecialResultIn`  in  64  second value.
- `registerFileOut`  out  64×16  architectural registers, registered.
- `busyOut`  out  16  bit r = pending count of register r nonzero.
- `stallOut`  out  1  combinational hazard stall to read stage.
- `retireCountOut`  out  32  accepted writeback transactions, wrapping.

## Operation
- FSM states IDLE, SPECIAL. Reset → IDLE.
- IDLE: `wbReadyOut`=1. On `wbValidIn`: write `wbResultIn` to `wbDestRegIn`, decrement its pending count, increment `retireCountOut`. If `wbSpecialValidIn`, latch special reg/value and go to SPECIAL.
- SPECIAL: `wbReadyOut`=0. Write the latched value to the latched register, decrement its count, return to IDLE. No retire increment (one per transaction).
- Primary and special indices equal: both writes occur in order; the final value is the special value. The count is decremented twice.
- Scoreboard: 2-bit saturating count per register. Reserve increments, writeback decrements. Reserve and release of the same register in one cycle leaves the count unchanged. The primary and special reserves of one instruction add 2 to a register they share.
- Decrement at count 0 is a protocol error: count stays 0 and the write still occurs.
- `stallOut` = (valid source with count≠0) OR (`reserveValidIn` and a reserve target count would exceed 3).
- A reserve while `stallOut`=1 is ignored; the read stage must hold it.
- Writes to all 16 indices are permitted, including RSP; no hardwired zero register.
- Reset: all registers 0, all counts 0, `busyOut`=0, `retireCountOut`=0, state IDLE, `wbReadyOut`=1, latched special state cleared. Reset during SPECIAL discards the pending special write.

## Timing
- Register write visible on `registerFileOut` the cycle after acceptance; the count decrement lands on the same edge. A dependent source therefore unstalls in exactly the cycle its value is visible; no bypass path.
- Single-destination throughput: 1 per cycle. Two-destination: 2 cycles, with ready low for the second.
- `stallOut` is purely combinational from current counts and inputs; `wbReadyOut` depends only on state, never on `wbValidIn`.
- `retireCountOut` wraps 0xFFFFFFFF → 0.

## Test plan
- Reset mid-SPECIAL (IMUL with RAX=5, RDX=6 accepted, `reset` asserted before the edge that writes RDX) → all 16 registers 0, `wbReadyOut`=1 asynchronously, RDX not written.
- Reserve R3, `sourceReg1In`=3 valid → `stallOut`=1. Writeback R3=0xDEAD → next cycle `registerFileOut[3]`=0xDEAD and `stallOut`=0.
- IMUL writeback with RAX=0x1111 and RDX=0x2222 → cycle 1 RAX written and `wbReadyOut`=0; cycle 2 RDX written; `retireCountOut` +1; a back-to-back second valid is held until ready.
- Same-cycle reserve and writeback of R7 at count 1 → count stays 1, `busyOut[7]`=1.
- Four reserves of R2 → fourth raises `stallOut`; three writebacks → `busyOut[2]`=0.
- Force `retireCountOut` to 0xFFFFFFFF, accept one writeback → 0.
